// File: rtl/alu_md_controller.sv
// -----------------------------------------------------------------------------
// alu_md_controller
//   Execute-stage ALU controller for the pipelined RISC-V core.
//   * Combinational decode of ALU_opc/func3/func7 into a 4-bit ALU control code
//     for the single-cycle ALU, with an explicit ILLEGAL code (15).
//   * Iterative radix-2 multiply/divide sequencer for RV32M/RV64M ops
//     (R-type, func7 = 0x01). It stalls the pipeline while an op is in flight.
//
// Parameters
//   WIDTH  datapath width in bits (32 or 64)
//   MD_EN  1 = M-extension sequencer present, 0 = M ops decode as illegal
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   ALU_opc    00 SW/LW, 01 BEQ, 10 R-type, 11 I-type
//   func3      instruction func3
//   func7      instruction func7 (I-type: only bit 5, for SRAI)
//   valid_in   EX stage holds a valid instruction
//   flush      synchronous abort of any M op in progress
//   op_a/op_b  rs1 / rs2 operands
//   ALU_cntr   ADD0 SUB1 AND2 OR3 SLT4 XOR5 SLTU6 SLL7 SRL8 SRA9 ILLEGAL15
//   illegal    decode matched no legal op
//   is_md      current decode is an M op
//   stall      hold IF/ID/EX while an M op is in progress
//   md_valid   md_result is valid this cycle
//   md_result  M-op result
// -----------------------------------------------------------------------------
module alu_md_controller #(
  parameter int WIDTH = 32,
  parameter bit MD_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       ALU_opc,
  input  logic [2:0]       func3,
  input  logic [6:0]       func7,
  input  logic             valid_in,
  input  logic             flush,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic [3:0]       ALU_cntr,
  output logic             illegal,
  output logic             is_md,
  output logic             stall,
  output logic             md_valid,
  output logic [WIDTH-1:0] md_result
);

  localparam logic [3:0] C_ADD  = 4'd0;
  localparam logic [3:0] C_SUB  = 4'd1;
  localparam logic [3:0] C_AND  = 4'd2;
  localparam logic [3:0] C_OR   = 4'd3;
  localparam logic [3:0] C_SLT  = 4'd4;
  localparam logic [3:0] C_XOR  = 4'd5;
  localparam logic [3:0] C_SLTU = 4'd6;
  localparam logic [3:0] C_SLL  = 4'd7;
  localparam logic [3:0] C_SRL  = 4'd8;
  localparam logic [3:0] C_SRA  = 4'd9;
  localparam logic [3:0] C_ILL  = 4'd15;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam int W2 = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH);

  // ---------------------------------------------------------------------------
  // Decode
  // ---------------------------------------------------------------------------
  // NOTE: every signal written in an always_comb gets a default first, so no
  // path through the case statements can leave it unassigned and infer a latch.
  always_comb begin
    ALU_cntr = C_ILL;
    is_md    = 1'b0;
    unique case (ALU_opc)
      2'b00: ALU_cntr = C_ADD;
      2'b01: ALU_cntr = C_SUB;
      2'b10: begin
        if (func7 == 7'h00) begin
          unique case (func3)
            3'd0: ALU_cntr = C_ADD;
            3'd1: ALU_cntr = C_SLL;
            3'd2: ALU_cntr = C_SLT;
            3'd3: ALU_cntr = C_SLTU;
            3'd4: ALU_cntr = C_XOR;
            3'd5: ALU_cntr = C_SRL;
            3'd6: ALU_cntr = C_OR;
            3'd7: ALU_cntr = C_AND;
          endcase
        end else if (func7 == 7'h20) begin
          if (func3 == 3'd0)      ALU_cntr = C_SUB;
          else if (func3 == 3'd5) ALU_cntr = C_SRA;
        end else if (func7 == 7'h01 && MD_EN) begin
          ALU_cntr = C_ADD;
          is_md    = 1'b1;
        end
      end
      2'b11: begin
        unique case (func3)
          3'd0: ALU_cntr = C_ADD;
          3'd1: ALU_cntr = C_SLL;
          3'd2: ALU_cntr = C_SLT;
          3'd3: ALU_cntr = C_SLTU;
          3'd4: ALU_cntr = C_XOR;
          3'd5: ALU_cntr = func7[5] ? C_SRA : C_SRL;
          3'd6: ALU_cntr = C_OR;
          3'd7: ALU_cntr = C_AND;
        endcase
      end
    endcase
    illegal = (ALU_cntr == C_ILL);
  end

  // ---------------------------------------------------------------------------
  // Multiply/divide sequencer
  // ---------------------------------------------------------------------------
  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic [2:0]       f3_q, f3_d;
  logic             neg_q, neg_d;
  logic [WIDTH-1:0] mag_q, mag_d;         // |op_a| for multiply, |op_b| for divide
  logic [W2-1:0]    acc_q, acc_d;         // {partial product | remainder, multiplier | quotient}
  logic [WIDTH-1:0] md_result_q, md_result_d;

  // Reset also blocks acceptance so stall reads 0 while rst is held.
  logic start;
  assign start = (state_q == S_IDLE) & valid_in & is_md & ~flush & ~rst;

  // Operand signedness: MUL/MULH/MULHSU/DIV/REM treat op_a as signed,
  // MUL/MULH/DIV/REM treat op_b as signed. MUL gives the same low half either way.
  logic             is_div, sign_a, sign_b, neg_start, div_zero, div_ovf;
  logic [WIDTH-1:0] abs_a, abs_b, special_res;

  assign is_div = func3[2];
  assign sign_a = op_a[WIDTH-1] & (func3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd6});
  assign sign_b = op_b[WIDTH-1] & (func3 inside {3'd0, 3'd1, 3'd4, 3'd6});
  assign abs_a  = sign_a ? -op_a : op_a;
  assign abs_b  = sign_b ? -op_b : op_b;
  // A remainder takes the sign of the dividend; everything else the xor.
  assign neg_start = (is_div & func3[1]) ? sign_a : (sign_a ^ sign_b);

  assign div_zero = is_div & (op_b == '0);
  assign div_ovf  = is_div & ~func3[0] & (op_a == {1'b1, {(WIDTH-1){1'b0}}}) & (&op_b);
  always_comb begin
    if (div_zero) special_res = func3[1] ? op_a : '1;
    else          special_res = func3[1] ? '0 : {1'b1, {(WIDTH-1){1'b0}}};
  end

  // Shift-add multiply: add the multiplicand into the upper half when the
  // current multiplier LSB is set, then shift the whole register right.
  logic [WIDTH:0]   mul_sum;
  logic [W2-1:0]    mul_next, mul_full;
  assign mul_sum  = {1'b0, acc_q[W2-1:WIDTH]} + (acc_q[0] ? {1'b0, mag_q} : '0);
  assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};
  assign mul_full = neg_q ? -mul_next : mul_next;

  // Restoring divide: shift left, trial-subtract the divisor from the upper
  // part and keep the difference only if it did not go negative.
  logic [WIDTH:0]   sh_hi, diff;
  logic [W2-1:0]    div_next;
  logic [WIDTH-1:0] div_out, div_fix, final_res;
  assign sh_hi    = acc_q[W2-1:WIDTH-1];
  assign diff     = sh_hi - {1'b0, mag_q};
  assign div_next = diff[WIDTH] ? {sh_hi[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                : {diff[WIDTH-1:0],  acc_q[WIDTH-2:0], 1'b1};
  assign div_out  = f3_q[1] ? div_next[W2-1:WIDTH] : div_next[WIDTH-1:0];
  assign div_fix  = neg_q ? -div_out : div_out;

  always_comb begin
    if (f3_q[2])              final_res = div_fix;
    else if (f3_q[1:0] == 0)  final_res = mul_full[WIDTH-1:0];
    else                      final_res = mul_full[W2-1:WIDTH];
  end

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    f3_d        = f3_q;
    neg_d       = neg_q;
    mag_d       = mag_q;
    acc_d       = acc_q;
    md_result_d = md_result_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          f3_d    = func3;
          neg_d   = neg_start;
          count_d = '0;
          mag_d   = is_div ? abs_b : abs_a;
          acc_d   = {{WIDTH{1'b0}}, (is_div ? abs_a : abs_b)};
          if (div_zero | div_ovf) begin
            md_result_d = special_res;
            state_d     = S_DONE;
          end else begin
            state_d = S_BUSY;
          end
        end
      end
      S_BUSY: begin
        acc_d   = f3_q[2] ? div_next : mul_next;
        count_d = count_q + CW'(1);
        if (count_q == CW'(WIDTH - 1)) begin
          md_result_d = final_res;
          state_d     = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;  // inputs still held here are not restarted
      default: state_d = S_IDLE;
    endcase
    if (flush) begin
      state_d     = S_IDLE;
      md_result_d = md_result_q;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      count_q     <= '0;
      f3_q        <= '0;
      neg_q       <= 1'b0;
      mag_q       <= '0;
      acc_q       <= '0;
      md_result_q <= '0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      f3_q        <= f3_d;
      neg_q       <= neg_d;
      mag_q       <= mag_d;
      acc_q       <= acc_d;
      md_result_q <= md_result_d;
    end
  end

  assign stall     = start | (state_q == S_BUSY);
  assign md_valid  = (state_q == S_DONE);
  assign md_result = md_result_q;

endmodule

// File: tb/tb_alu_md_controller.sv
module tb_alu_md_controller;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [1:0]  ALU_opc;
  logic [2:0]  func3;
  logic [6:0]  func7;
  logic        valid_in, valid_in64, flush;
  logic [31:0] op_a, op_b;
  logic [63:0] op_a64, op_b64;

  logic [3:0]  cntr32, cntr64, cntr_n;
  logic        ill32, ill64, ill_n;
  logic        md32, md64, md_n;
  logic        stall32, stall64, stall_n;
  logic        mdv32, mdv64, mdv_n;
  logic [31:0] res32, res_n;
  logic [63:0] res64;

  int n_vec = 0;
  int n_err = 0;

  alu_md_controller #(.WIDTH(32), .MD_EN(1'b1)) dut32 (
    .clk(clk), .rst(rst), .ALU_opc(ALU_opc), .func3(func3), .func7(func7),
    .valid_in(valid_in), .flush(flush), .op_a(op_a), .op_b(op_b),
    .ALU_cntr(cntr32), .illegal(ill32), .is_md(md32), .stall(stall32),
    .md_valid(mdv32), .md_result(res32));

  alu_md_controller #(.WIDTH(64), .MD_EN(1'b1)) dut64 (
    .clk(clk), .rst(rst), .ALU_opc(ALU_opc), .func3(func3), .func7(func7),
    .valid_in(valid_in64), .flush(flush), .op_a(op_a64), .op_b(op_b64),
    .ALU_cntr(cntr64), .illegal(ill64), .is_md(md64), .stall(stall64),
    .md_valid(mdv64), .md_result(res64));

  alu_md_controller #(.WIDTH(32), .MD_EN(1'b0)) dut_nomd (
    .clk(clk), .rst(rst), .ALU_opc(ALU_opc), .func3(func3), .func7(func7),
    .valid_in(valid_in), .flush(flush), .op_a(op_a), .op_b(op_b),
    .ALU_cntr(cntr_n), .illegal(ill_n), .is_md(md_n), .stall(stall_n),
    .md_valid(mdv_n), .md_result(res_n));

  // {opc, func3, func7, expected ALU_cntr, expected illegal, expected is_md}
  localparam int NDEC = 32;
  localparam logic [17:0] DEC_VECS [NDEC] = '{
    {2'b00, 3'd0, 7'h00, 4'd0,  1'b0, 1'b0},
    {2'b00, 3'd5, 7'h7f, 4'd0,  1'b0, 1'b0},
    {2'b01, 3'd3, 7'h00, 4'd1,  1'b0, 1'b0},
    {2'b10, 3'd0, 7'h00, 4'd0,  1'b0, 1'b0},
    {2'b10, 3'd1, 7'h00, 4'd7,  1'b0, 1'b0},
    {2'b10, 3'd2, 7'h00, 4'd4,  1'b0, 1'b0},
    {2'b10, 3'd3, 7'h00, 4'd6,  1'b0, 1'b0},
    {2'b10, 3'd4, 7'h00, 4'd5,  1'b0, 1'b0},
    {2'b10, 3'd5, 7'h00, 4'd8,  1'b0, 1'b0},
    {2'b10, 3'd6, 7'h00, 4'd3,  1'b0, 1'b0},
    {2'b10, 3'd7, 7'h00, 4'd2,  1'b0, 1'b0},
    {2'b10, 3'd0, 7'h20, 4'd1,  1'b0, 1'b0},
    {2'b10, 3'd5, 7'h20, 4'd9,  1'b0, 1'b0},
    {2'b10, 3'd1, 7'h20, 4'd15, 1'b1, 1'b0},
    {2'b10, 3'd7, 7'h20, 4'd15, 1'b1, 1'b0},
    {2'b10, 3'd0, 7'h01, 4'd0,  1'b0, 1'b1},
    {2'b10, 3'd7, 7'h01, 4'd0,  1'b0, 1'b1},
    {2'b10, 3'd0, 7'h02, 4'd15, 1'b1, 1'b0},
    {2'b10, 3'd5, 7'h7f, 4'd15, 1'b1, 1'b0},
    {2'b11, 3'd0, 7'h00, 4'd0,  1'b0, 1'b0},
    {2'b11, 3'd1, 7'h00, 4'd7,  1'b0, 1'b0},
    {2'b11, 3'd2, 7'h00, 4'd4,  1'b0, 1'b0},
    {2'b11, 3'd3, 7'h00, 4'd6,  1'b0, 1'b0},
    {2'b11, 3'd4, 7'h00, 4'd5,  1'b0, 1'b0},
    {2'b11, 3'd5, 7'h00, 4'd8,  1'b0, 1'b0},
    {2'b11, 3'd5, 7'h20, 4'd9,  1'b0, 1'b0},
    {2'b11, 3'd6, 7'h00, 4'd3,  1'b0, 1'b0},
    {2'b11, 3'd7, 7'h00, 4'd2,  1'b0, 1'b0},
    {2'b11, 3'd0, 7'h20, 4'd0,  1'b0, 1'b0},
    {2'b11, 3'd3, 7'h01, 4'd6,  1'b0, 1'b0},
    {2'b10, 3'd4, 7'h01, 4'd0,  1'b0, 1'b1},
    {2'b00, 3'd7, 7'h01, 4'd0,  1'b0, 1'b0}
  };

  localparam logic [2:0] F_MUL = 3'd0, F_MULH = 3'd1, F_MULHSU = 3'd2, F_MULHU = 3'd3;
  localparam logic [2:0] F_DIV = 3'd4, F_DIVU = 3'd5, F_REM = 3'd6, F_REMU = 3'd7;

  task automatic test_reset();
    rst = 1'b1; valid_in = 1'b0; valid_in64 = 1'b0; flush = 1'b0;
    ALU_opc = 2'b00; func3 = 3'd0; func7 = 7'h00;
    op_a = '0; op_b = '0; op_a64 = '0; op_b64 = '0;
    #1;
    n_vec++;
    if ({stall32, mdv32, res32} !== 34'd0) begin
      n_err++;
      $display("FAIL reset32: stall=%b md_valid=%b md_result=%h, want 0 0 0", stall32, mdv32, res32);
    end
    n_vec++;
    if ({stall64, mdv64, res64} !== 66'd0) begin
      n_err++;
      $display("FAIL reset64: stall=%b md_valid=%b md_result=%h, want 0 0 0", stall64, mdv64, res64);
    end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_decode();
    logic [17:0] v;
    valid_in = 1'b0;
    for (int i = 0; i < NDEC; i++) begin
      v = DEC_VECS[i];
      ALU_opc = v[17:16]; func3 = v[15:13]; func7 = v[12:6];
      #1;
      n_vec++;
      if ({cntr32, ill32, md32} !== v[5:0]) begin
        n_err++;
        $display("FAIL decode[%0d] opc=%b f3=%0d f7=%h: cntr=%0d ill=%b md=%b, want cntr=%0d ill=%b md=%b",
                 i, v[17:16], v[15:13], v[12:6], cntr32, ill32, md32, v[5:2], v[1], v[0]);
      end
    end
    // Without the sequencer an M op must decode as illegal.
    ALU_opc = 2'b10; func3 = 3'd0; func7 = 7'h01;
    #1;
    n_vec++;
    if ({cntr_n, ill_n, md_n} !== {4'd15, 1'b1, 1'b0}) begin
      n_err++;
      $display("FAIL decode_nomd: cntr=%0d ill=%b md=%b, want 15 1 0", cntr_n, ill_n, md_n);
    end
    // A non-M valid instruction must not start the sequencer.
    ALU_opc = 2'b10; func3 = 3'd4; func7 = 7'h00; valid_in = 1'b1;
    @(posedge clk); #1;
    n_vec++;
    if ({stall32, mdv32} !== 2'b00) begin
      n_err++;
      $display("FAIL nonmd_valid: stall=%b md_valid=%b, want 0 0", stall32, mdv32);
    end
    valid_in = 1'b0;
    @(posedge clk); #1;
  endtask

  // Issues one M op, holds it while stalled, and checks the cycle on which
  // md_valid appears, the number of stall cycles and the result.
  task automatic md_run(input bit w64, input logic [2:0] f3, input logic [63:0] a,
                        input logic [63:0] b, input logic [63:0] expv, input int exp_cyc,
                        input string name);
    int          stall_cnt = 0;
    int          done_cyc  = 0;
    logic        st, mv;
    logic [63:0] got = '0;
    ALU_opc = 2'b10; func7 = 7'h01; func3 = f3;
    if (w64) begin op_a64 = a; op_b64 = b; valid_in64 = 1'b1; end
    else     begin op_a = a[31:0]; op_b = b[31:0]; valid_in = 1'b1; end
    for (int c = 1; c <= exp_cyc + 8; c++) begin
      #1;
      st = w64 ? stall64 : stall32;
      mv = w64 ? mdv64 : mdv32;
      if (mv) begin
        done_cyc = c;
        got = w64 ? res64 : {32'd0, res32};
        break;
      end
      if (st) stall_cnt++;
      @(posedge clk);
    end
    valid_in = 1'b0; valid_in64 = 1'b0;
    n_vec++;
    if (done_cyc != exp_cyc) begin
      n_err++;
      if (done_cyc == 0) $display("FAIL %s latency: md_valid never seen, want cycle %0d", name, exp_cyc);
      else $display("FAIL %s latency: md_valid at cycle %0d, want %0d", name, done_cyc, exp_cyc);
    end
    n_vec++;
    if (stall_cnt != exp_cyc - 1) begin
      n_err++;
      $display("FAIL %s stall: %0d cycles, want %0d", name, stall_cnt, exp_cyc - 1);
    end
    n_vec++;
    if (got !== expv) begin
      n_err++;
      $display("FAIL %s result: got %h, want %h", name, got, expv);
    end
    @(posedge clk); #1;
    st = w64 ? stall64 : stall32;
    mv = w64 ? mdv64 : mdv32;
    n_vec++;
    if ({st, mv} !== 2'b00) begin
      n_err++;
      $display("FAIL %s after_done: stall=%b md_valid=%b, want 0 0", name, st, mv);
    end
  endtask

  task automatic test_mul();
    md_run(0, F_MUL,    64'hFFFFFFFF, 64'd2, 64'hFFFFFFFE, 34, "mul");
    md_run(0, F_MULHU,  64'hFFFFFFFF, 64'd2, 64'h00000001, 34, "mulhu");
    md_run(0, F_MULH,   64'hFFFFFFFF, 64'd2, 64'hFFFFFFFF, 34, "mulh");
    md_run(0, F_MULHSU, 64'hFFFFFFFF, 64'd2, 64'hFFFFFFFF, 34, "mulhsu");
    md_run(0, F_MUL,    64'd12345,    64'd1000, 64'd12345000, 34, "mul_pos");
  endtask

  task automatic test_div();
    md_run(0, F_DIV,  64'hFFFFFFF9, 64'd2, 64'hFFFFFFFD, 34, "div_neg");
    md_run(0, F_REM,  64'hFFFFFFF9, 64'd2, 64'hFFFFFFFF, 34, "rem_neg");
    md_run(0, F_DIVU, 64'd100,      64'd7, 64'd14,       34, "divu");
    md_run(0, F_REMU, 64'd100,      64'd7, 64'd2,        34, "remu");
  endtask

  task automatic test_div_special();
    md_run(0, F_DIVU, 64'd5,        64'd0,        64'hFFFFFFFF, 2, "divu_by0");
    md_run(0, F_REM,  64'd5,        64'd0,        64'd5,        2, "rem_by0");
    md_run(0, F_DIV,  64'h80000000, 64'hFFFFFFFF, 64'h80000000, 2, "div_ovf");
    md_run(0, F_REM,  64'h80000000, 64'hFFFFFFFF, 64'd0,        2, "rem_ovf");
  endtask

  task automatic test_flush();
    logic [31:0] prev;
    prev = res32;
    ALU_opc = 2'b10; func7 = 7'h01; func3 = F_MUL;
    op_a = 32'd3; op_b = 32'd5; valid_in = 1'b1;
    for (int i = 0; i < 11; i++) @(posedge clk);
    #1;
    n_vec++;
    if (stall32 !== 1'b1) begin
      n_err++;
      $display("FAIL flush_busy: stall=%b, want 1", stall32);
    end
    flush = 1'b1; valid_in = 1'b0;
    @(posedge clk); #1;
    flush = 1'b0;
    #1;
    n_vec++;
    if ({stall32, mdv32} !== 2'b00) begin
      n_err++;
      $display("FAIL flush_abort: stall=%b md_valid=%b, want 0 0", stall32, mdv32);
    end
    n_vec++;
    if (res32 !== prev) begin
      n_err++;
      $display("FAIL flush_result: md_result=%h, want held %h", res32, prev);
    end
    md_run(0, F_MUL, 64'd7, 64'd6, 64'd42, 34, "mul_after_flush");
  endtask

  task automatic test_reset_mid();
    ALU_opc = 2'b10; func7 = 7'h01; func3 = F_DIVU;
    op_a = 32'd100; op_b = 32'd7; valid_in = 1'b1;
    for (int i = 0; i < 5; i++) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    n_vec++;
    if ({stall32, mdv32, res32} !== 34'd0) begin
      n_err++;
      $display("FAIL reset_mid: stall=%b md_valid=%b md_result=%h, want 0 0 0", stall32, mdv32, res32);
    end
    valid_in = 1'b0;
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    n_vec++;
    if ({stall32, mdv32} !== 2'b00) begin
      n_err++;
      $display("FAIL reset_mid_after: stall=%b md_valid=%b, want 0 0", stall32, mdv32);
    end
    md_run(0, F_DIVU, 64'd100, 64'd7, 64'd14, 34, "divu_after_reset");
  endtask

  task automatic test_width64();
    md_run(1, F_MULHU, 64'h8000000000000000, 64'd4, 64'd2, 66, "mulhu64");
    md_run(1, F_MUL,   64'hFFFFFFFFFFFFFFFF, 64'd2, 64'hFFFFFFFFFFFFFFFE, 66, "mul64");
    md_run(1, F_DIV,   64'hFFFFFFFFFFFFFF9C, 64'd7, 64'hFFFFFFFFFFFFFFF2, 66, "div64");
  endtask

  initial begin
    test_reset();
    test_decode();
    test_mul();
    test_div();
    test_div_special();
    test_flush();
    test_reset_mid();
    test_width64();
    n_vec++;
    if (stall_n !== 1'b0 || mdv_n !== 1'b0) begin
      n_err++;
      $display("FAIL nomd_idle: stall=%b md_valid=%b, want 0 0", stall_n, mdv_n);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/alu_md_controller.md
Name: alu_md_controller

Overview:
- Next-generation execute-stage ALU controller for the pipelined RISC-V core.
- Decodes ALU_opc/func3/func7 into a 4-bit ALU control code for the single-cycle ALU; extended beyond the original with shifts and an explicit illegal code.
- Adds a parametrised iterative multiply/divide sequencer for RV32M/RV64M ops (func7 = 0x01), which stalls the pipeline while busy.

Parameters:
WIDTH, 32, datapath width in bits (32 or 64).
MD_EN, 1, 1 = M-extension sequencer present; 0 = M ops decode as illegal.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  reset, asynchronous, active-high.
ALU_opc  in  2  00 SW/LW, 01 BEQ, 10 R-type, 11 I-type.
func3  in  3  instruction func3.
func7  in  7  instruction func7 (for I-type, bit 5 only matters for SRAI).
valid_in  in  1  EX stage holds a valid instruction.
flush  in  1  synchronous abort of any M op in progress.
op_a  in  WIDTH  rs1 operand.
op_b  in  WIDTH  rs2 operand.
ALU_cntr  out  4  ADD0 SUB1 AND2 OR3 SLT4 XOR5 SLTU6 SLL7 SRL8 SRA9, ILLEGAL15.
illegal  out  1  decode matched no legal op.
is_md  out  1  current decode is an M op.
stall  out  1  hold IF/ID/EX; M op in progress.
md_valid  out  1  md_result valid this cycle.
md_result  out  WIDTH  M-op result.

Behaviour:
- Decode is combinational:
  - 00 -> ADD; 01 -> SUB.
  - 10, func7=0x00: f3 0 ADD, 1 SLL, 2 SLT, 3 SLTU, 4 XOR, 5 SRL, 6 OR, 7 AND.
  - 10, func7=0x20: f3 0 SUB, 5 SRA.
  - 11: f3 0 ADD, 2 SLT, 3 SLTU, 4 XOR, 6 OR, 7 AND, 1 SLL, 5 SRL/SRA selected by func7[5].
  - Anything else -> ALU_cntr = 15 and illegal = 1. No z outputs.
- M ops: ALU_opc = 10, func7 = 0x01, MD_EN = 1, giving is_md = 1 and ALU_cntr = ADD.
  - f3 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - If valid_in & is_md & !flush: latch magnitudes and sign flags, count = 0.
  - Stall is asserted combinationally in this same cycle.
  - Divide by zero or signed overflow goes directly to DONE; otherwise go to BUSY.
- BUSY:
  - One radix-2 step per cycle (shift-add multiply, restoring divide); count increments.
  - After WIDTH steps, apply sign correction, register md_result, go to DONE.
  - stall = 1 throughout.
- DONE:
  - stall = 0, md_valid = 1, md_result held; next state IDLE.
  - The instruction still on the inputs in DONE is not restarted.
- Latency: normal M op occupies WIDTH+2 cycles (accept, WIDTH steps, DONE), with stall high for WIDTH+1 cycles. Special divides occupy 2 cycles.
- Special cases (RISC-V spec):
  - Divide by zero: DIV/DIVU quotient = all ones; REM/REMU = op_a.
  - Overflow (MIN / -1): DIV = MIN, REM = 0.
- MUL returns the low WIDTH bits of the product. MULH* return the high WIDTH bits, using a 2*WIDTH product register.
- flush: in any state, next state IDLE; stall deasserts next cycle; md_valid is not asserted for the aborted op. In IDLE, flush blocks acceptance.
- Reset values: state IDLE, stall 0, md_valid 0, md_result 0, count 0. Reset mid-operation aborts immediately.
- A non-M valid_in never affects the FSM.

Test Plan:
- Decode sweep: all opc/func3/func7 combos -> codes as listed. Example: 10/f3=5/0x20 -> 9; 10/f3=1/0x20 -> 15 with illegal = 1.
- MUL, WIDTH=32, a=0xFFFFFFFF, b=2 -> stall high 33 cycles; md_valid cycle 34; MUL = 0xFFFFFFFE, MULHU = 0x00000001, MULH = 0xFFFFFFFF.
- DIV a=-7, b=2 -> quotient 0xFFFFFFFD, REM 0xFFFFFFFF. DIVU a=100, b=7 -> 14; REMU -> 2.
- Divide by zero: DIVU a=5, b=0 -> 0xFFFFFFFF. REM a=5, b=0 -> 5. Overflow: DIV 0x80000000 / -1 -> 0x80000000. Both with md_valid on cycle 2.
- flush at BUSY step 10 -> stall low next cycle, no md_valid. A new MUL issued next cycle completes correctly.
- rst asserted mid-divide -> stall, md_valid and md_result go to 0 immediately. Repeat the MUL test with WIDTH=64, MULHU(2^63, 4) = 2 after 66 cycles.
